// File: rtl/syst_node_pipe.sv
// rtl/syst_node_pipe.sv - systolic array node: weight daisy chain, activation forwarding, pipelined MAC
//
// Purpose: holds one weight and computes psumm_o = weight * x_i + psumm_i.
//   The result appears MUL_STAGES enabled cycles after the sample is captured.
//   The node can saturate or wrap on overflow, and it keeps a sticky overflow flag.
// Ports:
//   clk_i, rst_i (sync, active-low), en_i (global stall when 0)
//   w_load_i, weight_i -> w_o            weight capture and chain output
//   x_valid_i, x_i -> x_valid_o, x_o     activation forwarding, 1-cycle latency
//   psumm_i -> psumm_valid_o, psumm_o    partial sum in/out
//   clear_ovf_i -> ovf_o                 sticky overflow flag and its clear
module syst_node_pipe #(
  parameter int W_WIDTH    = 8,
  parameter int X_WIDTH    = 8,
  parameter int SI_WIDTH   = 17,
  parameter int SO_WIDTH   = 17,
  parameter int MUL_STAGES = 2,
  parameter int SIGNED     = 1,
  parameter int SATURATE   = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                w_load_i,
  input  logic [W_WIDTH-1:0]  weight_i,
  output logic [W_WIDTH-1:0]  w_o,
  input  logic                x_valid_i,
  input  logic [X_WIDTH-1:0]  x_i,
  input  logic [SI_WIDTH-1:0] psumm_i,
  output logic                x_valid_o,
  output logic [X_WIDTH-1:0]  x_o,
  output logic                psumm_valid_o,
  output logic [SO_WIDTH-1:0] psumm_o,
  input  logic                clear_ovf_i,
  output logic                ovf_o
);

  // The sum is formed one bit wider than the output so that overflow is observable.
  localparam int SW = SO_WIDTH + 1;
  // Depth of the raw-sum stages in front of the output register (at least 1 entry).
  localparam int DR = (MUL_STAGES > 1) ? MUL_STAGES - 1 : 1;

  logic [W_WIDTH-1:0]  weight_q;
  logic [X_WIDTH-1:0]  x_q;
  logic                x_valid_q;
  logic [DR-1:0]       rv_q;
  logic [SW-1:0]       raw_q [DR];
  logic                psumm_valid_q;
  logic [SO_WIDTH-1:0] psumm_q;
  logic                ovf_q;

  logic [SW-1:0]       w_ext, x_ext, ps_ext, prod, sum;
  logic [DR-1:0]       rv_in;
  logic [SW-1:0]       raw_in [DR];
  logic                fin_v;
  logic [SW-1:0]       fin_raw;
  logic                fin_ovf;
  logic [SO_WIDTH-1:0] fin_res;
  logic                ovf_d;

  // Multiply-add at SW bits. The weight register is read before the capturing edge,
  // so a simultaneous weight load does not affect this sample. Operands are extended
  // to SW bits, and only the low SW bits of the product are kept. Those bits are
  // correct for both signed and unsigned operands.
  always_comb begin
    w_ext  = {{(SW-W_WIDTH){(SIGNED != 0) && weight_q[W_WIDTH-1]}}, weight_q};
    x_ext  = {{(SW-X_WIDTH){(SIGNED != 0) && x_i[X_WIDTH-1]}}, x_i};
    ps_ext = {{(SW-SI_WIDTH){(SIGNED != 0) && psumm_i[SI_WIDTH-1]}}, psumm_i};
    prod   = w_ext * x_ext;
    sum    = prod + ps_ext;
  end

  // Stage k receives data from stage k-1. Stage 0 receives the freshly formed sum.
  always_comb begin
    rv_in[0]  = x_valid_i;
    raw_in[0] = sum;
    for (int k = 1; k < DR; k++) begin
      rv_in[k]  = rv_q[k-1];
      raw_in[k] = raw_q[k-1];
    end
    fin_v   = (MUL_STAGES == 1) ? x_valid_i : rv_q[DR-1];
    fin_raw = (MUL_STAGES == 1) ? sum       : raw_q[DR-1];
  end

  // Overflow detection and clamping are done on the way into the output register.
  always_comb begin
    if (SIGNED != 0) begin
      fin_ovf = fin_raw[SW-1] ^ fin_raw[SW-2];
    end else begin
      fin_ovf = fin_raw[SW-1];
    end
    fin_res = fin_raw[SO_WIDTH-1:0];
    if (fin_ovf && (SATURATE != 0)) begin
      if (SIGNED != 0) begin
        // The true sign of the result is the extra top bit.
        fin_res = fin_raw[SW-1] ? {1'b1, {(SO_WIDTH-1){1'b0}}}
                                : {1'b0, {(SO_WIDTH-1){1'b1}}};
      end else begin
        fin_res = {SO_WIDTH{1'b1}};
      end
    end
    // A new overflow takes priority over a clear on the same edge.
    ovf_d = (ovf_q && !clear_ovf_i) || (fin_v && fin_ovf);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      weight_q      <= '0;
      x_q           <= '0;
      x_valid_q     <= 1'b0;
      rv_q          <= '0;
      psumm_valid_q <= 1'b0;
      psumm_q       <= '0;
      ovf_q         <= 1'b0;
      for (int k = 0; k < DR; k++) begin
        raw_q[k] <= '0;
      end
    end else if (en_i) begin
      if (w_load_i) begin
        weight_q <= weight_i;
      end
      x_q       <= x_i;
      x_valid_q <= x_valid_i;
      rv_q      <= rv_in;
      // Data registers load only with a valid sample, so they hold their contents otherwise.
      for (int k = 0; k < DR; k++) begin
        if (rv_in[k]) begin
          raw_q[k] <= raw_in[k];
        end
      end
      psumm_valid_q <= fin_v;
      if (fin_v) begin
        psumm_q <= fin_res;
      end
      ovf_q <= ovf_d;
    end
  end

  assign w_o           = weight_q;
  assign x_o           = x_q;
  assign x_valid_o     = x_valid_q;
  assign psumm_valid_o = psumm_valid_q;
  assign psumm_o       = psumm_q;
  assign ovf_o         = ovf_q;

endmodule
